// File: rtl/adder_tb_pkg.sv
// adder_tb_pkg: shared types and widths for the adder self-test checker
package adder_tb_pkg;
    localparam int ADDER_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} chk_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;
    always_ff @(posedge clk)
        if (rst || clr) r_q <= '0;
        else if (inc && r_q != '1) r_q <= r_q + W'(1);
    assign q = r_q;
endmodule

// File: rtl/adder_check_unit.sv
// adder_check_unit: recomputes each adder result, counts pass/fail and keeps the first failing vector
module adder_check_unit
    import adder_tb_pkg::*;
#(
    parameter int WIDTH        = ADDER_W,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] y,
    input  logic             cout,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic             done,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH:0]   fail_got,
    output logic [WIDTH:0]   fail_exp
);
    chk_state_t       r_state, w_next;
    logic [CNT_W-1:0] r_rem;
    logic             r_stg_vld, r_stg_cin, r_err;
    logic [WIDTH-1:0] r_stg_a, r_stg_b, r_fail_a, r_fail_b;
    logic [WIDTH:0]   r_stg_got, r_fail_got, r_fail_exp;
    logic [WIDTH:0]   w_exp;
    logic             w_clr, w_acc, w_match, w_mis;

    assign w_clr   = start && (r_state == IDLE || r_state == DONE);
    assign w_acc   = in_valid && r_state == RUN;
    assign w_exp   = {1'b0, r_stg_a} + {1'b0, r_stg_b} + {{WIDTH{1'b0}}, r_stg_cin};
    assign w_match = w_exp == r_stg_got;
    assign w_mis   = r_stg_vld && !w_match;

    always_comb begin
        w_next = r_state;
        if (w_clr) w_next = num_vec != '0 ? RUN : DONE;
        else if (r_state == RUN && ((w_acc && r_rem == CNT_W'(1)) || (STOP_ON_FAIL && w_mis))) w_next = DRAIN;
        else if (r_state == DRAIN) w_next = DONE;
    end

    always_ff @(posedge clk)
        if (rst) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_stg_vld <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_stg_vld <= w_acc;
            if (w_clr) r_rem <= num_vec;
            else if (w_acc) r_rem <= r_rem - CNT_W'(1);
        end

    // Stage data needs no reset: it is only observed while r_stg_vld is set.
    always_ff @(posedge clk)
        if (w_acc) begin
            r_stg_a   <= a;
            r_stg_b   <= b;
            r_stg_cin <= cin;
            r_stg_got <= {cout, y};
        end

    always_ff @(posedge clk)
        if (rst || w_clr) begin
            r_err      <= 1'b0;
            r_fail_a   <= '0;
            r_fail_b   <= '0;
            r_fail_got <= '0;
            r_fail_exp <= '0;
        end else if (w_mis) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_fail_a   <= r_stg_a;
                r_fail_b   <= r_stg_b;
                r_fail_got <= r_stg_got;
                r_fail_exp <= w_exp;
            end
        end

    sat_counter #(.W(CNT_W)) u_pass (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(r_stg_vld && w_match), .q(pass_cnt)
    );
    sat_counter #(.W(CNT_W)) u_fail (
        .clk(clk), .rst(rst), .clr(w_clr), .inc(w_mis), .q(fail_cnt)
    );

    assign in_ready = r_state == RUN;
    assign done     = r_state == DONE;
    assign err      = r_err;
    assign fail_a   = r_fail_a;
    assign fail_b   = r_fail_b;
    assign fail_got = r_fail_got;
    assign fail_exp = r_fail_exp;
endmodule

// File: tb/tb_adder_check_unit.sv
// tb_adder_check_unit: directed vector tables for the adder checker in stop-on-fail, run-all and 2-bit-counter builds
module tb_adder_check_unit;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] y;
        logic        cout;
        logic        ok;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s = 1'b0, start_n = 1'b0, start_c = 1'b0;
    logic        in_valid = 1'b0, cin = 1'b0, cout = 1'b0;
    logic [15:0] num_vec = '0;
    logic [31:0] a = '0, b = '0, y = '0;
    int          sel = 0;
    int          tests = 0, fails = 0;

    logic        rdy_s, err_s, done_s, rdy_n, err_n, done_n, rdy_c, err_c, done_c, rdy;
    logic [15:0] pc_s, fc_s, pc_n, fc_n;
    logic [1:0]  pc_c, fc_c;
    logic [31:0] fa_s, fb_s, fa_n, fb_n, fa_c, fb_c;
    logic [32:0] fg_s, fe_s, fg_n, fe_n, fg_c, fe_c;

    always #5 clk = ~clk;
    assign rdy = sel == 0 ? rdy_s : sel == 1 ? rdy_n : rdy_c;

    adder_check_unit #(.WIDTH(32), .CNT_W(16), .STOP_ON_FAIL(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .num_vec(num_vec), .in_valid(in_valid),
        .in_ready(rdy_s), .a(a), .b(b), .cin(cin), .y(y), .cout(cout),
        .pass_cnt(pc_s), .fail_cnt(fc_s), .err(err_s), .done(done_s),
        .fail_a(fa_s), .fail_b(fb_s), .fail_got(fg_s), .fail_exp(fe_s)
    );
    adder_check_unit #(.WIDTH(32), .CNT_W(16), .STOP_ON_FAIL(1'b0)) dut_n (
        .clk(clk), .rst(rst), .start(start_n), .num_vec(num_vec), .in_valid(in_valid),
        .in_ready(rdy_n), .a(a), .b(b), .cin(cin), .y(y), .cout(cout),
        .pass_cnt(pc_n), .fail_cnt(fc_n), .err(err_n), .done(done_n),
        .fail_a(fa_n), .fail_b(fb_n), .fail_got(fg_n), .fail_exp(fe_n)
    );
    adder_check_unit #(.WIDTH(32), .CNT_W(2), .STOP_ON_FAIL(1'b0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .num_vec(num_vec[1:0]), .in_valid(in_valid),
        .in_ready(rdy_c), .a(a), .b(b), .cin(cin), .y(y), .cout(cout),
        .pass_cnt(pc_c), .fail_cnt(fc_c), .err(err_c), .done(done_c),
        .fail_a(fa_c), .fail_b(fb_c), .fail_got(fg_c), .fail_exp(fe_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; cin = v.cin; y = v.y; cout = v.cout;
    endtask

    task automatic send(input vec_t v);
        drive(v);
        in_valid = 1'b1;
        for (int n = 0; !rdy && n < 20; n++) tick;
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready got 0 expected 1");
        end
        tick;
    endtask

    task automatic run_start(input int s, input logic [15:0] nv);
        sel = s;
        num_vec = nv;
        start_s = s == 0;
        start_n = s == 1;
        start_c = s == 2;
        tick;
        start_s = 1'b0; start_n = 1'b0; start_c = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t t1[4], t2[5], t3[5];
        vec_t bad;
        int   ep, ef;
        t1[0] = '{32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        t1[1] = '{32'h1, 32'h3, 1'b0, 32'h4, 1'b0, 1'b1};
        t1[2] = '{32'h2, 32'h6, 1'b0, 32'h8, 1'b0, 1'b1};
        t1[3] = '{32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1};
        t2[0] = '{32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b1};
        t2[1] = '{32'd7, 32'd8, 1'b1, 32'd16, 1'b0, 1'b1};
        t2[2] = '{32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b1};
        t2[3] = '{32'd5, 32'd7, 1'b1, 32'h0000000C, 1'b0, 1'b0};
        t2[4] = '{32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b1};
        t3[0] = '{32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b1};
        t3[1] = '{32'd3, 32'd4, 1'b0, 32'd8, 1'b0, 1'b0};
        t3[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1};
        t3[3] = '{32'h100, 32'h200, 1'b0, 32'h300, 1'b1, 1'b0};
        t3[4] = '{32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b1};
        bad   = '{32'd1, 32'd1, 1'b0, 32'd3, 1'b0, 1'b0};

        tick; tick;
        chk("rst_ready", rdy_s, 0);
        chk("rst_done", done_s, 0);
        chk("rst_err", err_s, 0);
        chk("rst_pass", pc_s, 0);
        chk("rst_fail", fc_s, 0);
        chk("rst_fail_got", fg_s, 0);
        rst = 1'b0;

        run_start(0, 4);
        chk("t1_ready", rdy_s, 1);
        for (int i = 0; i < 4; i++) send(t1[i]);
        in_valid = 1'b0;
        chk("t1_drain_ready", rdy_s, 0);
        chk("t1_drain_done", done_s, 0);
        tick;
        chk("t1_done", done_s, 1);
        chk("t1_pass", pc_s, 4);
        chk("t1_fail", fc_s, 0);
        chk("t1_err", err_s, 0);

        run_start(0, 10);
        chk("t2_cleared_pass", pc_s, 0);
        for (int i = 0; i < 5; i++) send(t2[i]);
        chk("t2_ready_drop", rdy_s, 0);
        chk("t2_err", err_s, 1);
        chk("t2_fail_early", fc_s, 1);
        chk("t2_pass_early", pc_s, 3);
        in_valid = 1'b0;
        tick;
        chk("t2_done", done_s, 1);
        chk("t2_pass", pc_s, 4);
        chk("t2_fail", fc_s, 1);
        chk("t2_fail_a", fa_s, 32'd5);
        chk("t2_fail_b", fb_s, 32'd7);
        chk("t2_fail_got", fg_s, 33'h00000000C);
        chk("t2_fail_exp", fe_s, 33'h00000000D);

        run_start(1, 5);
        ep = 0; ef = 0;
        for (int i = 0; i < 5; i++) begin
            send(t3[i]);
            if (t3[i].ok) ep++; else ef++;
        end
        in_valid = 1'b0;
        tick;
        chk("t3_done", done_n, 1);
        chk("t3_pass", pc_n, 64'(ep));
        chk("t3_fail", fc_n, 64'(ef));
        chk("t3_err", err_n, 1);
        chk("t3_fail_a", fa_n, 32'd3);
        chk("t3_fail_b", fb_n, 32'd4);
        chk("t3_fail_got", fg_n, 33'h000000008);
        chk("t3_fail_exp", fe_n, 33'h000000007);

        run_start(0, 0);
        chk("t4_done", done_s, 1);
        chk("t4_ready", rdy_s, 0);
        chk("t4_pass", pc_s, 0);
        chk("t4_fail", fc_s, 0);
        chk("t4_err", err_s, 0);
        chk("t4_fail_a", fa_s, 0);
        drive(t1[1]);
        in_valid = 1'b1;
        tick; tick; tick;
        in_valid = 1'b0;
        tick;
        chk("t4_ignored_pass", pc_s, 0);
        chk("t4_still_done", done_s, 1);

        run_start(0, 5);
        send(t1[1]);
        send(bad);
        in_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t5_ready", rdy_s, 0);
        chk("t5_done", done_s, 0);
        chk("t5_pass", pc_s, 0);
        chk("t5_fail", fc_s, 0);
        chk("t5_err", err_s, 0);
        chk("t5_fail_got", fg_s, 0);
        run_start(0, 3);
        for (int i = 0; i < 3; i++) send(t1[i]);
        in_valid = 1'b0;
        tick;
        chk("t5_rerun_done", done_s, 1);
        chk("t5_rerun_pass", pc_s, 3);
        chk("t5_rerun_fail", fc_s, 0);

        run_start(2, 3);
        drive(bad);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            tick;
            chk($sformatf("t6_fail_%0d", k), fc_c, 64'(k + 1));
            chk($sformatf("t6_done_%0d", k), done_c, 64'(k == 2));
        end
        chk("t6_pass", pc_c, 0);
        chk("t6_err", err_c, 1);
        chk("t6_fail_exp", fe_c, 33'h000000002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
